// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and raster helper functions
// for the VGA timing generator and the pixel blocks that decode its coordinates.
package vga_timing_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  // 1280x1024@60 at a 108 MHz pixel clock
  localparam int SXGA_H_VISIBLE = 1280;
  localparam int SXGA_H_FP      = 48;
  localparam int SXGA_H_SYNC    = 112;
  localparam int SXGA_H_BP      = 248;
  localparam int SXGA_V_VISIBLE = 1024;
  localparam int SXGA_V_FP      = 1;
  localparam int SXGA_V_SYNC    = 3;
  localparam int SXGA_V_BP      = 38;

  // 640x480@60 at a 25.175 MHz pixel clock
  localparam int VGA_H_VISIBLE  = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_V_VISIBLE  = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bits_t;

  function automatic int span_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int visible, input int fp);
    return visible + fp;
  endfunction

  function automatic int sync_end(input int visible, input int fp, input int sync);
    return visible + fp + sync;
  endfunction

  // Half-open window [lo, hi), unsigned compare on raster coordinates
  function automatic logic in_window(input coord_t value, input coord_t lo,
                                     input coord_t hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle produced by vga_timing_gen and consumed by the pixel-condition
// blocks and the display mux.
interface vga_timing_gen_if import vga_timing_pkg::*; ();

  coord_t VGA_horzCoord;
  coord_t VGA_vertCoord;
  logic   VGA_active;
  logic   VGA_HS;
  logic   VGA_VS;
  logic   LINE_START;
  logic   FRAME_START;
  logic   VGA_HS_D;
  logic   VGA_VS_D;
  logic   VGA_active_D;

  modport master (
    output VGA_horzCoord, VGA_vertCoord, VGA_active, VGA_HS, VGA_VS,
           LINE_START, FRAME_START, VGA_HS_D, VGA_VS_D, VGA_active_D
  );

  modport slave (
    input  VGA_horzCoord, VGA_vertCoord, VGA_active, VGA_HS, VGA_VS,
           LINE_START, FRAME_START, VGA_HS_D, VGA_VS_D, VGA_active_D
  );

endinterface

// File: rtl/pix_delay_line.sv
// Enable-gated shift register; DEPTH=0 collapses to a combinational wire so the
// delayed outputs track the undelayed ones exactly.
module pix_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign dout        = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stages[i] <= RESET_VAL;
        end
      end else if (en) begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stages[i] <= stages[i-1];
        end
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter with sync/active decode and start pulses, plus a pixel-tick
// delayed copy of sync/active for registered downstream pixel pipelines.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int   H_VISIBLE  = SXGA_H_VISIBLE,
  parameter int   H_FP       = SXGA_H_FP,
  parameter int   H_SYNC     = SXGA_H_SYNC,
  parameter int   H_BP       = SXGA_H_BP,
  parameter int   V_VISIBLE  = SXGA_V_VISIBLE,
  parameter int   V_FP       = SXGA_V_FP,
  parameter int   V_SYNC     = SXGA_V_SYNC,
  parameter int   V_BP       = SXGA_V_BP,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   SYNC_DELAY = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PIX_EN,
  vga_timing_gen_if.master vga
);

  localparam int     H_TOTAL  = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL  = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(sync_start(H_VISIBLE, H_FP));
  localparam coord_t HS_END   = coord_t'(sync_end(H_VISIBLE, H_FP, H_SYNC));
  localparam coord_t VS_START = coord_t'(sync_start(V_VISIBLE, V_FP));
  localparam coord_t VS_END   = coord_t'(sync_end(V_VISIBLE, V_FP, V_SYNC));

  coord_t     horz_q, vert_q;
  coord_t     horz_nxt, vert_nxt;
  logic       hs_q, vs_q, active_q;
  logic       hs_nxt, vs_nxt, active_nxt;
  logic       line_start_q, frame_start_q;
  logic       line_start_nxt, frame_start_nxt;
  sync_bits_t sync_now, sync_dly;

  // Decode uses the next coordinates so registered flags line up with the coords
  always_comb begin
    horz_nxt = horz_q;
    vert_nxt = vert_q;
    if (PIX_EN) begin
      if (horz_q == H_LAST) begin
        horz_nxt = '0;
        vert_nxt = (vert_q == V_LAST) ? '0 : vert_q + 1'b1;
      end else begin
        horz_nxt = horz_q + 1'b1;
      end
    end

    hs_nxt          = in_window(horz_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_nxt          = in_window(vert_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    active_nxt      = (horz_nxt < H_VIS) && (vert_nxt < V_VIS);
    line_start_nxt  = PIX_EN && (horz_nxt == '0);
    frame_start_nxt = line_start_nxt && (vert_nxt == '0);
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0)
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      horz_q        <= H_LAST;
      vert_q        <= V_LAST;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      horz_q        <= horz_nxt;
      vert_q        <= vert_nxt;
      hs_q          <= hs_nxt;
      vs_q          <= vs_nxt;
      active_q      <= active_nxt;
      line_start_q  <= line_start_nxt;
      frame_start_q <= frame_start_nxt;
    end
  end

  assign sync_now = '{hs: hs_q, vs: vs_q, active: active_q};

  pix_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_delay (
    .clk   (CLK),
    .rst_n (RESET_N),
    .en    (PIX_EN),
    .din   (sync_now),
    .dout  (sync_dly)
  );

  assign vga.VGA_horzCoord = horz_q;
  assign vga.VGA_vertCoord = vert_q;
  assign vga.VGA_active    = active_q;
  assign vga.VGA_HS        = hs_q;
  assign vga.VGA_VS        = vs_q;
  assign vga.LINE_START    = line_start_q;
  assign vga.FRAME_START   = frame_start_q;
  assign vga.VGA_HS_D      = sync_dly.hs;
  assign vga.VGA_VS_D      = sync_dly.vs;
  assign vga.VGA_active_D  = sync_dly.active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size SXGA instance (3-tick delay) and a tiny raster
// (negative sync, no delay) run side by side against a behavioural raster model.
module tb_vga_timing_gen;

  typedef struct {
    int hv, hfp, hsy, hbp;
    int vv, vfp, vsy, vbp;
    bit pol;
    int dly;
  } tim_t;

  typedef struct {
    int       h, v;
    bit       ls, fs;
    bit [7:0] hist_hs, hist_vs, hist_act;
  } model_t;

  typedef struct {
    logic [31:0] h, v;
    logic act, hs, vs, ls, fs, hs_d, vs_d, act_d;
  } exp_t;

  localparam tim_t T_FULL  = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 3};
  localparam tim_t T_SMALL = '{16, 2, 3, 4, 8, 1, 2, 3, 1'b0, 0};

  logic CLK = 1'b0;
  logic RESET_N;
  logic PIX_EN;

  always #5 CLK = ~CLK;

  vga_timing_gen_if bus_full  ();
  vga_timing_gen_if bus_small ();

  vga_timing_gen #(.SYNC_DELAY(3)) dut_full (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PIX_EN  (PIX_EN),
    .vga     (bus_full)
  );

  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
    .V_VISIBLE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL  (1'b0), .SYNC_DELAY (0)
  ) dut_small (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PIX_EN  (PIX_EN),
    .vga     (bus_small)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  model_t m_full, m_small;
  exp_t   q_full[$], q_small[$];
  bit     last_en, last_rn, stats_on;

  int hs_cnt = 0, hs_first = -1, hsd_first = -1;
  int s_frames = 0, s_ticks = 0, s_act = 0;
  int s_period = -1, s_act_period = -1, vs_min = 9999, vs_max = -1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic model_t modelStep(model_t m, tim_t t, bit en, bit rn);
    model_t n;
    int     ht, vt;
    bit     hs_b, vs_b, act_b;
    n  = m;
    ht = t.hv + t.hfp + t.hsy + t.hbp;
    vt = t.vv + t.vfp + t.vsy + t.vbp;
    if (!rn) begin
      n.h        = ht - 1;
      n.v        = vt - 1;
      n.ls       = 1'b0;
      n.fs       = 1'b0;
      n.hist_hs  = {8{~t.pol}};
      n.hist_vs  = {8{~t.pol}};
      n.hist_act = 8'h00;
    end else if (en) begin
      if (m.h == ht - 1) begin
        n.h = 0;
        n.v = (m.v == vt - 1) ? 0 : m.v + 1;
      end else begin
        n.h = m.h + 1;
      end
      n.ls       = (n.h == 0);
      n.fs       = n.ls && (n.v == 0);
      hs_b       = (n.h >= t.hv + t.hfp && n.h < t.hv + t.hfp + t.hsy) ? t.pol : ~t.pol;
      vs_b       = (n.v >= t.vv + t.vfp && n.v < t.vv + t.vfp + t.vsy) ? t.pol : ~t.pol;
      act_b      = (n.h < t.hv) && (n.v < t.vv);
      n.hist_hs  = {m.hist_hs[6:0], hs_b};
      n.hist_vs  = {m.hist_vs[6:0], vs_b};
      n.hist_act = {m.hist_act[6:0], act_b};
    end else begin
      n.ls = 1'b0;
      n.fs = 1'b0;
    end
    return n;
  endfunction

  function automatic exp_t modelOut(model_t m, tim_t t);
    exp_t e;
    e.h     = m.h;
    e.v     = m.v;
    e.act   = m.hist_act[0];
    e.hs    = m.hist_hs[0];
    e.vs    = m.hist_vs[0];
    e.ls    = m.ls;
    e.fs    = m.fs;
    e.hs_d  = m.hist_hs[t.dly];
    e.vs_d  = m.hist_vs[t.dly];
    e.act_d = m.hist_act[t.dly];
    return e;
  endfunction

  function automatic exp_t sampleFull();
    exp_t a;
    a.h = 32'(bus_full.VGA_horzCoord); a.v = 32'(bus_full.VGA_vertCoord);
    a.act = bus_full.VGA_active; a.hs = bus_full.VGA_HS; a.vs = bus_full.VGA_VS;
    a.ls = bus_full.LINE_START; a.fs = bus_full.FRAME_START;
    a.hs_d = bus_full.VGA_HS_D; a.vs_d = bus_full.VGA_VS_D; a.act_d = bus_full.VGA_active_D;
    return a;
  endfunction

  function automatic exp_t sampleSmall();
    exp_t a;
    a.h = 32'(bus_small.VGA_horzCoord); a.v = 32'(bus_small.VGA_vertCoord);
    a.act = bus_small.VGA_active; a.hs = bus_small.VGA_HS; a.vs = bus_small.VGA_VS;
    a.ls = bus_small.LINE_START; a.fs = bus_small.FRAME_START;
    a.hs_d = bus_small.VGA_HS_D; a.vs_d = bus_small.VGA_VS_D; a.act_d = bus_small.VGA_active_D;
    return a;
  endfunction

  task automatic compareExp(input string who, input exp_t a, input exp_t e);
    checkOutput({who, ".horz"},   a.h,     e.h);
    checkOutput({who, ".vert"},   a.v,     e.v);
    checkOutput({who, ".active"}, a.act,   e.act);
    checkOutput({who, ".hs"},     a.hs,    e.hs);
    checkOutput({who, ".vs"},     a.vs,    e.vs);
    checkOutput({who, ".line"},   a.ls,    e.ls);
    checkOutput({who, ".frame"},  a.fs,    e.fs);
    checkOutput({who, ".hs_d"},   a.hs_d,  e.hs_d);
    checkOutput({who, ".vs_d"},   a.vs_d,  e.vs_d);
    checkOutput({who, ".act_d"},  a.act_d, e.act_d);
  endtask

  task automatic collectStats();
    if (!(stats_on && last_rn && last_en)) return;
    if (bus_full.VGA_vertCoord == 12'd6) begin
      if (bus_full.VGA_HS === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bus_full.VGA_horzCoord);
      end
      if (bus_full.VGA_HS_D === 1'b1 && hsd_first < 0) hsd_first = int'(bus_full.VGA_horzCoord);
    end
    if (bus_small.FRAME_START === 1'b1) begin
      if (s_frames == 1) begin
        s_period     = s_ticks;
        s_act_period = s_act;
      end
      s_frames++;
      s_ticks = 0;
      s_act   = 0;
    end
    s_ticks++;
    if (bus_small.VGA_active === 1'b1) s_act++;
    if (bus_small.VGA_VS === 1'b0) begin
      if (int'(bus_small.VGA_vertCoord) < vs_min) vs_min = int'(bus_small.VGA_vertCoord);
      if (int'(bus_small.VGA_vertCoord) > vs_max) vs_max = int'(bus_small.VGA_vertCoord);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit rn);
    exp_t e;
    PIX_EN  = en;
    RESET_N = rn;
    last_en = en;
    last_rn = rn;
    m_full  = modelStep(m_full, T_FULL, en, rn);
    m_small = modelStep(m_small, T_SMALL, en, rn);
    q_full.push_back(modelOut(m_full, T_FULL));
    q_small.push_back(modelOut(m_small, T_SMALL));
    @(posedge CLK);
    #1;
    e = q_full.pop_front();
    compareExp("full", sampleFull(), e);
    e = q_small.pop_front();
    compareExp("small", sampleSmall(), e);
    collectStats();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    RESET_N  = 1'b0;
    PIX_EN   = 1'b0;
    stats_on = 1'b0;
    m_full   = '{default: 0};
    m_small  = '{default: 0};

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("release.frame_start", bus_full.FRAME_START, 1'b1);

    stats_on = 1'b1;
    for (int i = 0; i < 7 * 1688 + 10; i++) applyStimulus(1'b1, 1'b1);
    stats_on = 1'b0;
    checkOutput("full.hs_width",       hs_cnt,       112);
    checkOutput("full.hs_first_horz",  hs_first,     1328);
    checkOutput("full.hsd_first_horz", hsd_first,    1331);
    checkOutput("small.frame_ticks",   s_period,     350);
    checkOutput("small.active_ticks",  s_act_period, 128);
    checkOutput("small.vs_first_line", vs_min,       9);
    checkOutput("small.vs_last_line",  vs_max,       10);

    for (int i = 0; i < 160; i++) applyStimulus((i % 2) == 0, 1'b1);

    guard = 0;
    while (!(m_small.h == 8 && m_small.v == 4) && guard < 400) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    checkOutput("small.reach_midframe", guard < 400, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midreset.act_d", bus_small.VGA_active_D, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart.frame_start", bus_small.FRAME_START, 1'b1);
    for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA_horzCoord / VGA_vertCoord raster that all pixel-condition blocks (glyphs, labels, waveform overlays) decode, plus HS/VS sync and active-video flag.
- Default timing: 1280x1024@60 at the 108 MHz pixel rate.
- Sits between the clock tree and the display mux.
- Provides sync/active delayed by a parameterised number of pixels so they stay aligned with registered downstream pixel logic.

Parameters:
- H_VISIBLE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, horizontal sync width (pixels)
- H_BP, 248, horizontal back porch (pixels); H_TOTAL = sum of the four H values = 1688
- V_VISIBLE, 1024, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines); V_TOTAL = 1066
- SYNC_POL, 1, active level of HS/VS (1 = positive)
- SYNC_DELAY, 1, pixel delay (0..7) applied to the *_D outputs

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  synchronous active-low reset
- PIX_EN  in  1  pixel tick; counters advance only when high
- VGA_horzCoord  out  12  current column, 0..H_TOTAL-1
- VGA_vertCoord  out  12  current line, 0..V_TOTAL-1
- VGA_active  out  1  high when coord < (H_VISIBLE, V_VISIBLE)
- VGA_HS  out  1  horizontal sync, aligned with coords
- VGA_VS  out  1  vertical sync, aligned with coords
- LINE_START  out  1  one-CLK pulse when horz enters 0
- FRAME_START  out  1  one-CLK pulse when coords enter (0,0)
- VGA_HS_D  out  1  VGA_HS delayed SYNC_DELAY pixel ticks
- VGA_VS_D  out  1  VGA_VS delayed SYNC_DELAY pixel ticks
- VGA_active_D  out  1  VGA_active delayed SYNC_DELAY pixel ticks

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous, active-low on RESET_N, sampled on the CLK rising edge.
- All outputs are registered. Sync/active/pulse registers are computed from next-counter values, so they are valid in the same cycle as the coords they describe.
- Reset values, held while RESET_N=0:
  - horz = H_TOTAL-1 (1687), vert = V_TOTAL-1 (1065)
  - VGA_active = 0
  - HS and VS = ~SYNC_POL
  - LINE_START = FRAME_START = 0
  - delay line filled with (~SYNC_POL, ~SYNC_POL, 0)
- Consequence: the first PIX_EN after reset release lands on (0,0) with FRAME_START.
- Reset mid-frame: the next CLK edge forces the reset state regardless of PIX_EN.
- Counting on PIX_EN=1:
  - horz==H_TOTAL-1 → horz=0 and vert increments.
  - Otherwise horz increments.
  - vert==V_TOTAL-1 at the line wrap → vert=0.
- PIX_EN=0 holds coords, HS, VS, active and the delay line unchanged.
- Decode:
  - HS = SYNC_POL when H_VISIBLE+H_FP <= horz < H_VISIBLE+H_FP+H_SYNC (1328..1439).
  - VS = SYNC_POL when V_VISIBLE+V_FP <= vert < V_VISIBLE+V_FP+V_SYNC (1025..1027).
  - HS/VS are ~SYNC_POL otherwise.
  - VGA_active = (horz < H_VISIBLE) && (vert < V_VISIBLE).
- Pulses:
  - LINE_START is high exactly one CLK after the PIX_EN edge that sets horz=0, and clears on the next CLK even if PIX_EN stays low.
  - FRAME_START is the same, additionally requiring vert=0.
  - Both pulses are high together at the frame wrap.
- Arithmetic: counters are 12-bit unsigned. Totals up to 4095 are supported, and compares are unsigned.
- Delay line:
  - SYNC_DELAY-deep shift of {HS, VS, active}, advanced only on PIX_EN.
  - SYNC_DELAY=0 makes *_D equal to the undelayed outputs, combinationally.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 1280x1024@60 and 640x480@60
  - COORD_W = 12
  - derived H_TOTAL/V_TOTAL and sync-start/end functions
- Sub-module pix_delay_line(WIDTH, DEPTH, RESET_VAL): enable-gated shift register used for the *_D outputs.

Test Plan:
1. Reset: hold RESET_N=0 for 5 cycles with PIX_EN=1 → coords (1687,1065), active 0, HS=VS=0, pulses 0. Release and apply one PIX_EN → coords (0,0), FRAME_START=LINE_START=1 for 1 cycle, active 1.
2. Line wrap: continuous PIX_EN from (1687,5) → (0,6), LINE_START=1, FRAME_START=0. HS is high for exactly 112 ticks starting at horz=1328.
3. Frame wrap: run a full frame → VS is high for lines 1025..1027 only, and FRAME_START recurs after 1688*1066 = 1,799,408 ticks. active is high for exactly 1,310,720 ticks per frame.
4. PIX_EN gating: toggle PIX_EN 1/0 alternately → coords advance once per 2 CLK, LINE_START width stays 1 CLK, and all outputs hold while PIX_EN=0.
5. Delay: SYNC_DELAY=3 → VGA_HS_D rises exactly 3 PIX_EN ticks after VGA_HS (at horz=1331). With SYNC_DELAY=0, *_D equals the undelayed signals.
6. Mid-frame reset: assert RESET_N=0 at (640,512) for 1 cycle → reset state on the next edge, delay line cleared (VGA_active_D=0), and the restart at (0,0) follows.
